// File: rtl/magma_pkg.sv
// Shared widths, FSM encodings and the round-to-subkey index mapping
// for the Magma block controller.
package magma_pkg;

    localparam int BLOCK_W  = 64;
    localparam int KEY_W    = 256;
    localparam int SUBKEY_W = 32;
    localparam int ROUNDS   = 32;
    localparam int CNT_W    = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    // Index 0..7 selects K1..K8. Encrypt walks forward three times then backward;
    // decrypt walks forward once then backward three times.
    function automatic logic [2:0] key_idx(input logic [CNT_W-1:0] cnt, input logic decrypt);
        logic [2:0] idx;
        if (decrypt)
            idx = (cnt[4:3] == 2'b00) ? cnt[2:0] : ~cnt[2:0];
        else
            idx = (cnt[4:3] == 2'b11) ? ~cnt[2:0] : cnt[2:0];
        return idx;
    endfunction

endpackage

// File: rtl/magma_key_sched.sv
// Combinational subkey select from the latched 256-bit key and the round count.
module magma_key_sched
    import magma_pkg::*;
(
    input  logic [KEY_W-1:0]    key,
    input  logic [CNT_W-1:0]    cnt,
    input  logic                decrypt,
    output logic [SUBKEY_W-1:0] subkey
);

    logic [2:0] idx;

    always_comb begin
        idx    = key_idx(cnt, decrypt);
        subkey = '0;
        for (int k = 0; k < 8; k++) begin
            if (idx == 3'(k))
                subkey = key[KEY_W-1-SUBKEY_W*k -: SUBKEY_W];
        end
    end

endmodule

// File: rtl/round.sv
// Single Magma round with half swap: {hi, lo} -> {lo, g(lo + k) ^ hi}.
// Samples istart, odone follows two edges later with the result on oblock.
module round (
    input  logic        iclk,
    input  logic        irst,
    input  logic        istart,
    input  logic [63:0] iblock,
    input  logic [31:0] ikey,
    output logic [63:0] oblock,
    output logic        odone
);

    // S-boxes pi7..pi0; entry v of box s lives at bits [64*s + 4*v +: 4].
    localparam logic [511:0] SBOX = {
        64'h2BC96AF43850DE71, 64'h73AD0B4FC19652E8,
        64'h0E34187BAC296FD5, 64'hC24BE390D618A5F7,
        64'hB9E35A076F4D128C, 64'h069C471EDAF2853B,
        64'hF0DB74E1C5A93286, 64'h1F307D8E9B5A264C
    };

    function automatic logic [31:0] g_func(input logic [31:0] a);
        logic [31:0] t;
        t = '0;
        for (int s = 0; s < 8; s++)
            t[4*s +: 4] = SBOX[64*s + 4*int'(a[4*s +: 4]) +: 4];
        return {t[20:0], t[31:21]};
    endfunction

    logic        s1_valid, s2_valid;
    logic [31:0] s1_hi, s1_lo, s1_sum;
    logic [31:0] s2_hi, s2_lo, s2_g;

    always_ff @(posedge iclk) begin
        if (irst) begin
            s1_valid <= 1'b0;
            s1_hi    <= '0;
            s1_lo    <= '0;
            s1_sum   <= '0;
            s2_valid <= 1'b0;
            s2_hi    <= '0;
            s2_lo    <= '0;
            s2_g     <= '0;
            oblock   <= '0;
            odone    <= 1'b0;
        end else begin
            s1_valid <= istart;
            if (istart) begin
                s1_hi  <= iblock[63:32];
                s1_lo  <= iblock[31:0];
                s1_sum <= iblock[31:0] + ikey;
            end
            s2_valid <= s1_valid;
            s2_hi    <= s1_hi;
            s2_lo    <= s1_lo;
            s2_g     <= g_func(s1_sum);
            odone    <= s2_valid;
            if (s2_valid)
                oblock <= {s2_lo, s2_g ^ s2_hi};
        end
    end

endmodule

// File: rtl/magma_cipher_ctrl.sv
// Runs one 64-bit block through 32 Magma rounds using the shared round datapath.
// Handshake: istart is taken only in IDLE; obusy covers the run; odone pulses once with oblock valid.
module magma_cipher_ctrl
    import magma_pkg::*;
(
    input  logic               iclk,
    input  logic               irst_n,
    input  logic               istart,
    input  logic               idecrypt,
    input  logic [KEY_W-1:0]   ikey,
    input  logic [BLOCK_W-1:0] iblock,
    output logic [BLOCK_W-1:0] oblock,
    output logic               obusy,
    output logic               odone
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [BLOCK_W-1:0]  blk;
    logic [KEY_W-1:0]    key;
    logic                decrypt;

    logic                round_rst;
    logic                round_start;
    logic                round_done;
    logic [BLOCK_W-1:0]  round_block;
    logic [SUBKEY_W-1:0] subkey;

    assign round_rst   = ~irst_n;
    assign round_start = (state == ST_START);

    magma_key_sched u_key_sched (
        .key     (key),
        .cnt     (cnt),
        .decrypt (decrypt),
        .subkey  (subkey)
    );

    round u_round (
        .iclk   (iclk),
        .irst   (round_rst),
        .istart (round_start),
        .iblock (blk),
        .ikey   (subkey),
        .oblock (round_block),
        .odone  (round_done)
    );

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            blk     <= '0;
            key     <= '0;
            decrypt <= 1'b0;
            oblock  <= '0;
            obusy   <= 1'b0;
            odone   <= 1'b0;
        end else begin
            odone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (istart) begin
                        blk     <= iblock;
                        key     <= ikey;
                        decrypt <= idecrypt;
                        cnt     <= '0;
                        obusy   <= 1'b1;
                        state   <= ST_START;
                    end
                end
                ST_START: state <= ST_WAIT;
                ST_WAIT: begin
                    if (round_done) begin
                        blk <= round_block;
                        if (cnt == LAST_CNT) begin
                            state <= ST_FIN;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= ST_START;
                        end
                    end
                end
                ST_FIN: begin
                    // The round always swaps halves; undo the swap of round 32.
                    oblock <= {blk[31:0], blk[63:32]};
                    odone  <= 1'b1;
                    obusy  <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
